serial_receiver_44bits: RTL and testbench
=========================================

Name: serial_receiver_44bits

Overview:
- Serial-in, parallel-out deserializer; the receive-side counterpart of the 44-bit serial transmitter in the PCI-UART adapter.
- Samples one bit per clock, LSB first, starting at a frame-start strobe.
- After 44 bits, presents the assembled word on a parallel output with a valid/ready handshake toward the PCI-side logic.
- Exposes a remaining-bit count on `workload`, matching the transmitter's busy indication.

Parameters:
- WIDTH, 44, data bits per frame.
- CNT_W, 6, width of `workload`; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  1  serial data bit, sampled every rising clk edge while receiving.
- in_start  input  1  high in the cycle `in_data` carries bit 0 of a frame.
- out_data  output  WIDTH  last completed word; bit 0 = first received bit.
- out_valid  output  1  `out_data` holds an unconsumed word.
- out_ready  input  1  consumer accepts word when out_valid & out_ready.
- overrun  output  1  one-cycle pulse: a completed word overwrote an unconsumed one.
- workload  output  CNT_W  bits still to be sampled in the current frame; 0 = idle.

Behaviour:
- Reset (async on rst_n low): state=IDLE, shift reg=0, out_data=0, out_valid=0, overrun=0, workload=0. Reset mid-frame discards partial data; no out_valid follows.
- States: IDLE, SHIFT.
- IDLE:
  - in_start=1: sample in_data into sr[WIDTH-1], workload<=WIDTH-1, go SHIFT.
  - Otherwise hold. in_data is ignored in IDLE.
- SHIFT, each cycle: sr<={in_data, sr[WIDTH-1:1]}, workload<=workload-1.
- SHIFT, cycle where workload==1 (last bit):
  - out_data<={in_data, sr[WIDTH-1:1]}, out_valid<=1.
  - Go IDLE, workload<=0.
- in_start during SHIFT is ignored; no resync mid-frame.
- Frame occupies exactly WIDTH consecutive cycles. A new frame may start in the cycle immediately after the last bit (back-to-back, zero gap).
- Latency: out_valid rises on the clock edge that samples the last bit, i.e. visible the cycle after that bit was presented.
- Handshake: out_valid & out_ready at an edge clears out_valid, unless a new word completes at that same edge.
- Completion with out_valid=1 and out_ready=0: out_data overwritten, out_valid stays 1, overrun=1 for one cycle.
- Completion with out_valid=1 and out_ready=1 at the same edge: new word loaded, out_valid stays 1, no overrun.
- overrun is otherwise 0.
- workload is a down-counter: never wraps, never exceeds WIDTH-1 (WIDTH with parity option).

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits; the extra last bit is even parity over the data bits.
  - workload loads WIDTH on start.
  - Added output port parity_err (1 bit, reset 0), updated at each word completion: 1 if XOR(data, parity bit)!=0.
  - parity_err holds until the next completion.
  - out_data/out_valid behave as without the option; the parity bit is not stored in out_data.
- Undefined: frame is WIDTH bits, no parity_err port.

Test Plan:
- Reset, then in_start with serial LSB-first 44'h123_4567_89AB, out_ready=1 -> out_valid pulses 1 cycle after bit 43; out_data=44'h123_4567_89AB; workload runs 43..0.
- Two back-to-back frames 44'hFFF_FFFF_FFFF then 44'h000_0000_0001, out_ready=0 -> second completion gives out_data=44'h000_0000_0001, out_valid=1, overrun pulse=1.
- Second completion at the same edge as out_ready=1 -> out_valid stays 1, overrun=0, out_data=second word.
- rst_n low at bit 20 of a frame, then a new frame 44'hA5A_5A5A_5A5A -> no out_valid for the aborted frame; second word correct.
- in_start pulsed at bit 10 mid-frame -> ignored; 44'hDEA_DBEE_F012 received intact.
- SERIAL_RX_PARITY_EN defined, 44'h000_0000_0003 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/serial_receiver_44bits.sv
// Serial-in, parallel-out deserializer: LSB-first frames with a valid/ready word output.
// Optional even-parity bit per frame and parity_err output when SERIAL_RX_PARITY_EN is defined.
module serial_receiver_44bits #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data,
    input  logic             in_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] workload
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SERIAL_RX_PARITY_EN
    // The trailing parity bit is not stored, so the shifter holds all data bits.
    localparam int unsigned SR_W = WIDTH;
    localparam int unsigned LOAD = WIDTH;
`else
    // The last data bit goes straight to out_data, so one bit less of storage.
    localparam int unsigned SR_W = WIDTH - 1;
    localparam int unsigned LOAD = WIDTH - 1;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_RX_PARITY_EN
    logic               perr_q, perr_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state: frame sequencing, word completion and handshake
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        ovr_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    sr_d    = {in_data, sr_q[SR_W-1:1]};
                    cnt_d   = CNT_W'(LOAD);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef SERIAL_RX_PARITY_EN
                    data_d = sr_q;
                    perr_d = (^sr_q) ^ in_data;
`else
                    sr_d   = {in_data, sr_q[SR_W-1:1]};
                    data_d = {in_data, sr_q};
`endif
                    valid_d = 1'b1;
                    ovr_d   = valid_q & ~out_ready;
                    state_d = IDLE;
                end else begin
                    sr_d = {in_data, sr_q[SR_W-1:1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign workload  = cnt_q;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_receiver_44bits.sv
// Directed bench for serial_receiver_44bits; parity cases run when SERIAL_RX_PARITY_EN is defined.
module tb_serial_receiver_44bits;

    localparam int unsigned WIDTH = 44;
    localparam int unsigned CNT_W = 6;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_data;
    logic             in_start;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic [CNT_W-1:0] workload;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err;
`endif

    int vectors;
    int miscompares;

    serial_receiver_44bits #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_start   (in_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .workload   (workload)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one frame; out_ready takes rdy_last in the last bit cycle, glitch is an extra in_start bit index.
    task automatic send(input logic [WIDTH-1:0] w, input logic par, input logic rdy_last, input int glitch);
        for (int i = 0; i < FRAME; i++) begin
            in_start = (i == 0) || (i == glitch);
            in_data  = (i < int'(WIDTH)) ? w[i] : par;
            if (i == FRAME - 1) out_ready = rdy_last;
            step();
            check("workload", 64'(workload), 64'(FRAME - 1 - i));
        end
        in_start = 1'b0;
        in_data  = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_start  = 1'b0;
        in_data   = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_workload", 64'(workload), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
`ifdef SERIAL_RX_PARITY_EN
        check("rst_parity_err", 64'(parity_err), 64'd0);
`endif
        rst_n = 1'b1;
        step();

        // Single frame, consumer ready
        w = 44'h123_4567_89AB;
        send(w, ^w, 1'b1, -1);
        check("f1_valid", 64'(out_valid), 64'd1);
        check("f1_data", 64'(out_data), 64'h123_4567_89AB);
        check("f1_overrun", 64'(overrun), 64'd0);
`ifdef SERIAL_RX_PARITY_EN
        check("f1_parity_err", 64'(parity_err), 64'd0);
`endif
        step();
        check("f1_consumed", 64'(out_valid), 64'd0);

        // Back-to-back frames with consumer stalled
        out_ready = 1'b0;
        w = 44'hFFF_FFFF_FFFF;
        send(w, ^w, 1'b0, -1);
        check("b2b1_valid", 64'(out_valid), 64'd1);
        check("b2b1_data", 64'(out_data), 64'hFFF_FFFF_FFFF);
        check("b2b1_overrun", 64'(overrun), 64'd0);
        w = 44'h000_0000_0001;
        send(w, ^w, 1'b0, -1);
        check("b2b2_valid", 64'(out_valid), 64'd1);
        check("b2b2_data", 64'(out_data), 64'h000_0000_0001);
        check("b2b2_overrun", 64'(overrun), 64'd1);
        step();
        check("ovr_pulse_end", 64'(overrun), 64'd0);
        check("ovr_valid_held", 64'(out_valid), 64'd1);

        // Completion coincides with consumption of the pending word
        w = 44'h5A5_0F0F_3C3C;
        send(w, ^w, 1'b1, -1);
        check("same_edge_valid", 64'(out_valid), 64'd1);
        check("same_edge_overrun", 64'(overrun), 64'd0);
        check("same_edge_data", 64'(out_data), 64'h5A5_0F0F_3C3C);
        step();
        check("same_edge_consumed", 64'(out_valid), 64'd0);

        // Reset mid-frame at bit 20
        w = 44'h0F0_F0F0_F0F0;
        for (int i = 0; i < 20; i++) begin
            in_start = (i == 0);
            in_data  = w[i];
            step();
        end
        in_start = 1'b0;
        check("pre_abort_workload", 64'(workload), 64'(FRAME - 20));
        rst_n = 1'b0;
        #1;
        check("abort_workload", 64'(workload), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (FRAME) step();
        check("abort_no_valid", 64'(out_valid), 64'd0);
        check("abort_idle", 64'(workload), 64'd0);
        w = 44'hA5A_5A5A_5A5A;
        send(w, ^w, 1'b1, -1);
        check("post_abort_valid", 64'(out_valid), 64'd1);
        check("post_abort_data", 64'(out_data), 64'hA5A_5A5A_5A5A);
        step();

        // in_start pulsed mid-frame is ignored
        w = 44'hDEA_DBEE_F012;
        send(w, ^w, 1'b1, 10);
        check("resync_valid", 64'(out_valid), 64'd1);
        check("resync_data", 64'(out_data), 64'hDEA_DBEE_F012);
        step();
        check("idle_after", 64'(out_valid), 64'd0);

`ifdef SERIAL_RX_PARITY_EN
        // Parity bit wrong then right for 44'h3
        w = 44'h000_0000_0003;
        send(w, 1'b1, 1'b1, -1);
        check("par_bad_err", 64'(parity_err), 64'd1);
        check("par_bad_data", 64'(out_data), 64'h000_0000_0003);
        step();
        check("par_err_held", 64'(parity_err), 64'd1);
        send(w, 1'b0, 1'b1, -1);
        check("par_good_err", 64'(parity_err), 64'd0);
        check("par_good_valid", 64'(out_valid), 64'd1);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
